// File: rtl/wb_bfm_burst_memory.sv
// Wishbone B3 slave memory: byte-lane writes, wait states, CTI/BTE incrementing and
// wrapping bursts with next-address read lookahead, and an optional out-of-range error.
module wb_bfm_burst_memory #(
  parameter int          DW          = 32,
  parameter int          AW          = 32,
  parameter int          MEM_WORDS   = 1024,
  parameter int unsigned BASE_ADR    = 0,
  parameter int          WAIT_STATES = 0,
  parameter int          ERR_OOR     = 1
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  output logic [DW-1:0]   wb_sdt_o,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_rty_o
);

  localparam int            SW    = DW / 8;
  localparam int            OFS   = $clog2(SW);
  localparam int            IW    = $clog2(MEM_WORDS);
  localparam logic [AW-1:0] BASE  = AW'(BASE_ADR);
  localparam logic [AW-1:0] DEPTH = AW'(MEM_WORDS);
  localparam logic [AW-1:0] ONE   = AW'(1'b1);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_WAIT        = 2'd1,
    S_CLASSIC_ACK = 2'd2,
    S_BURST       = 2'd3
  } state_t;

  state_t        r_state;
  logic [3:0]    r_wait;
  logic [AW-1:0] r_word;
  logic          r_oor;
  logic [2:0]    r_cti;
  logic [1:0]    r_bte;
  logic          r_ack;
  logic          r_err;
  logic [DW-1:0] r_sdt;
  logic [DW-1:0] r_mem [MEM_WORDS];

  logic [AW:0]   w_sub;
  logic [AW-1:0] w_in_word;
  logic          w_in_oor;
  logic [AW-1:0] w_mask;
  logic [AW-1:0] w_next_word;
  logic          w_next_oor;
  logic          w_go;
  logic          w_beat;
  logic          w_last;
  logic [AW-1:0] w_look_word;
  logic          w_look_oor;
  logic [2:0]    w_dec_cti;
  logic          w_decide;
  logic          w_wr_en;

  function automatic logic f_oor(input logic [AW-1:0] word);
    f_oor = (ERR_OOR != 0) && (word >= DEPTH);
  endfunction

  // Word-index bits allowed to change on a wrapping burst; linear bursts change all of them
  function automatic logic [AW-1:0] f_wrap_mask(input logic [1:0] bte);
    case (bte)
      2'b01:   f_wrap_mask = AW'(4'd3);
      2'b10:   f_wrap_mask = AW'(4'd7);
      2'b11:   f_wrap_mask = AW'(4'd15);
      default: f_wrap_mask = {AW{1'b1}};
    endcase
  endfunction

  // Address decode, burst next-address and ack-decision select
  always_comb begin
    w_sub       = {1'b0, wb_adr_i} - {1'b0, BASE};
    w_in_word   = w_sub[AW-1:0] >> OFS;
    w_in_oor    = f_oor(w_in_word) || ((ERR_OOR != 0) && w_sub[AW]);
    w_mask      = f_wrap_mask(r_bte);
    w_next_word = (r_word & ~w_mask) | ((r_word + ONE) & w_mask);
    w_next_oor  = f_oor(w_next_word);
    w_go        = wb_cyc_i && wb_stb_i;
    w_beat      = w_go && (r_state == S_BURST);
    w_last      = (wb_cti_i == 3'b111) || (wb_cti_i == 3'b000);
    if (r_state == S_IDLE) begin
      w_look_word = w_in_word;
      w_look_oor  = w_in_oor;
      w_dec_cti   = wb_cti_i;
      w_decide    = w_go && (WAIT_STATES == 0);
    end else begin
      w_look_word = r_word;
      w_look_oor  = r_oor;
      w_dec_cti   = r_cti;
      w_decide    = w_go && (r_state == S_WAIT) && (r_wait == 4'd0);
    end
    w_wr_en = !wb_rst_i && w_go && wb_we_i && !r_oor &&
              ((r_state == S_CLASSIC_ACK) || (r_state == S_BURST));
  end

  // Burst beats follow stb in the same cycle so a paused master is never acked
  assign wb_ack_o = r_ack || (w_beat && !r_oor);
  assign wb_err_o = r_err || (w_beat && r_oor);
  assign wb_sdt_o = r_sdt;
  assign wb_rty_o = 1'b0;

  // Access FSM with registered classic ack/err and read-data lookahead
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_wait  <= 4'd0;
      r_word  <= {AW{1'b0}};
      r_oor   <= 1'b0;
      r_cti   <= 3'b000;
      r_bte   <= 2'b00;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_sdt   <= {DW{1'b0}};
    end else if (!wb_cyc_i) begin
      r_state <= S_IDLE;
      r_wait  <= 4'd0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ack <= 1'b0;
          r_err <= 1'b0;
          if (wb_stb_i) begin
            r_word  <= w_in_word;
            r_oor   <= w_in_oor;
            r_cti   <= wb_cti_i;
            r_bte   <= wb_bte_i;
            r_state <= S_WAIT;
            r_wait  <= 4'(WAIT_STATES - 1);
          end
        end
        S_WAIT: begin
          if (!wb_stb_i) begin
            r_state <= S_IDLE;
          end else if (r_wait != 4'd0) begin
            r_wait <= r_wait - 4'd1;
          end
        end
        S_CLASSIC_ACK: begin
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        S_BURST: begin
          if (wb_stb_i) begin
            if (w_last) begin
              r_state <= S_IDLE;
            end else begin
              r_word <= w_next_word;
              r_oor  <= w_next_oor;
              r_sdt  <= w_next_oor ? {DW{1'b0}} : r_mem[w_next_word[IW-1:0]];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // End of the wait period: the first beat's data and response are set up together
      if (w_decide) begin
        r_sdt <= w_look_oor ? {DW{1'b0}} : r_mem[w_look_word[IW-1:0]];
        if (w_dec_cti == 3'b010) begin
          r_state <= S_BURST;
        end else begin
          r_state <= S_CLASSIC_ACK;
          r_ack   <= !w_look_oor;
          r_err   <= w_look_oor;
        end
      end
    end
  end

  // Byte-lane write on the acked cycle; contents are deliberately not reset
  always_ff @(posedge wb_clk_i) begin
    if (w_wr_en) begin
      for (int b = 0; b < SW; b++) begin
        if (wb_sel_i[b]) begin
          r_mem[r_word[IW-1:0]][b*8 +: 8] <= wb_dat_i[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_bfm_burst_memory.sv
// Directed bench for wb_bfm_burst_memory: a zero-wait 256-word instance and a
// three-wait-state instance share the master signals, selected by their own cyc.
module tb_wb_bfm_burst_memory;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, we, stb, cyc0, cyc3, use3;
  logic [31:0] adr, dat;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] sdt0, sdt3;
  logic        ack0, ack3, err0, err3, rty0, rty3;
  logic        m_ack, m_err;
  logic [31:0] m_sdt;

  assign m_ack = use3 ? ack3 : ack0;
  assign m_err = use3 ? err3 : err0;
  assign m_sdt = use3 ? sdt3 : sdt0;

  int vectors = 0;
  int miscompares = 0;

  int          c_lat;
  logic        c_ack, c_err, c_after;
  logic [31:0] c_dat;
  logic [31:0] bd [16];
  logic        be [16];
  int          b_first, b_gaps, b_quiet, b_bad;

  wb_bfm_burst_memory #(.DW(32), .AW(32), .MEM_WORDS(256), .BASE_ADR(0),
                        .WAIT_STATES(0), .ERR_OOR(1)) dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc0), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_sdt_o(sdt0), .wb_ack_o(ack0), .wb_err_o(err0), .wb_rty_o(rty0));

  wb_bfm_burst_memory #(.DW(32), .AW(32), .MEM_WORDS(1024), .BASE_ADR(0),
                        .WAIT_STATES(3), .ERR_OOR(1)) dut3 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc3), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_sdt_o(sdt3), .wb_ack_o(ack3), .wb_err_o(err3), .wb_rty_o(rty3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic s, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] sl, input logic [2:0] ct,
                       input logic [1:0] bt);
    cyc0 = c && !use3;
    cyc3 = c && use3;
    stb = s; we = w; adr = a; dat = d; sel = sl; cti = ct; bte = bt;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 2'b00);
    tick();
  endtask

  // Classic cycle: latency counted in cycles from the stb cycle; one stb-low cycle after ack
  task automatic bus_classic(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] sl);
    c_lat = -1; c_ack = 1'b0; c_err = 1'b0; c_dat = 32'h0; c_after = 1'b1;
    drive(1'b1, 1'b1, w, a, d, sl, 3'b000, 2'b00);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (m_ack || m_err) begin
        c_lat = k; c_ack = m_ack; c_err = m_err; c_dat = m_sdt;
        tick();
        break;
      end
      tick();
    end
    stb = 1'b0;
    @(negedge clk);
    c_after = m_ack || m_err;
    tick();
    idle();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus_classic(1'b1, a, d, 4'hF);
  endtask

  // Read burst; ends with cyc still high and stb low so a following cycle starts back to back
  task automatic bus_burst(input logic [31:0] a, input int n, input logic [1:0] bt,
                           input int stall_at, input int stall_len);
    int beat, cyc_n, stall;
    beat = 0; cyc_n = 0; stall = 0;
    b_first = -1; b_gaps = 0; b_quiet = 0; b_bad = 0;
    for (int i = 0; i < 16; i++) begin
      bd[i] = 32'h0; be[i] = 1'b0;
    end
    drive(1'b1, 1'b1, 1'b0, a, 32'h0, 4'hF, (n == 1) ? 3'b111 : 3'b010, bt);
    while (beat < n && cyc_n < 60) begin
      @(negedge clk);
      if (!stb) begin
        if (m_ack || m_err) b_bad++;
        else b_quiet++;
      end else if (m_ack || m_err) begin
        bd[beat] = m_sdt; be[beat] = m_err;
        if (beat == 0) b_first = cyc_n;
        beat++;
      end else if (beat > 0) begin
        b_gaps++;
      end
      tick();
      cyc_n++;
      if (beat == stall_at && stall < stall_len) begin
        stb = 1'b0; stall++;
      end else begin
        stb = 1'b1; cti = (beat == n - 1) ? 3'b111 : 3'b010;
      end
    end
    stb = 1'b0; cti = 3'b000;
  endtask

  task automatic test_reset();
    rst = 1'b1; use3 = 1'b0;
    idle(); tick(); tick();
    @(negedge clk);
    vectors++; if (ack0 !== 1'b0) begin miscompares++; $display("FAIL rst_ack0: got %b, expected 0", ack0); end
    vectors++; if (err0 !== 1'b0) begin miscompares++; $display("FAIL rst_err0: got %b, expected 0", err0); end
    vectors++; if (rty0 !== 1'b0) begin miscompares++; $display("FAIL rst_rty0: got %b, expected 0", rty0); end
    vectors++; if (sdt0 !== 32'h0) begin miscompares++; $display("FAIL rst_sdt0: got %h, expected 0", sdt0); end
    vectors++; if (ack3 !== 1'b0) begin miscompares++; $display("FAIL rst_ack3: got %b, expected 0", ack3); end
    vectors++; if (sdt3 !== 32'h0) begin miscompares++; $display("FAIL rst_sdt3: got %h, expected 0", sdt3); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_classic();
    use3 = 1'b0;
    wr(32'h10, 32'hDEADBEEF);
    vectors++; if (c_lat !== 1) begin miscompares++; $display("FAIL wr_latency: got %0d, expected 1", c_lat); end
    vectors++; if (c_ack !== 1'b1 || c_err !== 1'b0) begin miscompares++; $display("FAIL wr_resp: got ack %b err %b, expected ack 1 err 0", c_ack, c_err); end
    vectors++; if (c_after !== 1'b0) begin miscompares++; $display("FAIL wr_ack_single: got %b, expected 0", c_after); end
    bus_classic(1'b0, 32'h10, 32'h0, 4'hF);
    vectors++; if (c_lat !== 1) begin miscompares++; $display("FAIL rd_latency: got %0d, expected 1", c_lat); end
    vectors++; if (c_dat !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_data: got %h, expected deadbeef", c_dat); end
    vectors++; if (c_after !== 1'b0) begin miscompares++; $display("FAIL rd_ack_single: got %b, expected 0", c_after); end
  endtask

  task automatic test_byte_lanes();
    use3 = 1'b0;
    wr(32'h20, 32'h11223344);
    bus_classic(1'b1, 32'h20, 32'hAA000000, 4'b1000);
    bus_classic(1'b0, 32'h20, 32'h0, 4'hF);
    vectors++; if (c_dat !== 32'hAA223344) begin miscompares++; $display("FAIL lane_merge: got %h, expected aa223344", c_dat); end
    bus_classic(1'b1, 32'h20, 32'h55555555, 4'b0000);
    vectors++; if (c_ack !== 1'b1) begin miscompares++; $display("FAIL sel0_ack: got %b, expected 1", c_ack); end
    bus_classic(1'b0, 32'h20, 32'h0, 4'hF);
    vectors++; if (c_dat !== 32'hAA223344) begin miscompares++; $display("FAIL sel0_nowrite: got %h, expected aa223344", c_dat); end
  endtask

  task automatic test_wrap_burst();
    logic [31:0] exp_w [4];
    exp_w = '{32'd2, 32'd3, 32'd0, 32'd1};
    use3 = 1'b0;
    for (int i = 0; i < 4; i++) wr(32'(i * 4), 32'(i));
    bus_burst(32'h08, 4, 2'b01, 99, 0);
    vectors++; if (b_first !== 1) begin miscompares++; $display("FAIL wrap_first: got %0d, expected 1", b_first); end
    vectors++; if (b_gaps !== 0) begin miscompares++; $display("FAIL wrap_gaps: got %0d, expected 0", b_gaps); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (bd[i] !== exp_w[i]) begin miscompares++; $display("FAIL wrap_beat%0d: got %h, expected %h", i, bd[i], exp_w[i]); end
    end
  endtask

  task automatic test_back_to_back();
    use3 = 1'b0;
    bus_classic(1'b0, 32'h04, 32'h0, 4'hF);
    vectors++; if (c_lat !== 1) begin miscompares++; $display("FAIL b2b_latency: got %0d, expected 1", c_lat); end
    vectors++; if (c_dat !== 32'h1) begin miscompares++; $display("FAIL b2b_data: got %h, expected 1", c_dat); end
  endtask

  task automatic test_wait_states();
    use3 = 1'b1;
    for (int i = 0; i < 8; i++) wr(32'(32'h40 + i * 4), 32'(32'h100 + i));
    bus_classic(1'b0, 32'h40, 32'h0, 4'hF);
    vectors++; if (c_lat !== 4) begin miscompares++; $display("FAIL ws3_latency: got %0d, expected 4", c_lat); end
    vectors++; if (c_dat !== 32'h100) begin miscompares++; $display("FAIL ws3_data: got %h, expected 100", c_dat); end
    bus_burst(32'h40, 8, 2'b00, 99, 0);
    vectors++; if (b_first !== 4) begin miscompares++; $display("FAIL ws3_burst_first: got %0d, expected 4", b_first); end
    vectors++; if (b_gaps !== 0) begin miscompares++; $display("FAIL ws3_burst_gaps: got %0d, expected 0", b_gaps); end
    for (int i = 0; i < 8; i++) begin
      vectors++; if (bd[i] !== 32'(32'h100 + i)) begin miscompares++; $display("FAIL ws3_beat%0d: got %h, expected %h", i, bd[i], 32'h100 + i); end
    end
    idle();
    use3 = 1'b0;
  endtask

  task automatic test_out_of_range();
    use3 = 1'b0;
    bus_classic(1'b0, 32'h400, 32'h0, 4'hF);
    vectors++; if (c_err !== 1'b1 || c_ack !== 1'b0) begin miscompares++; $display("FAIL oor_rd_resp: got err %b ack %b, expected err 1 ack 0", c_err, c_ack); end
    vectors++; if (c_dat !== 32'h0) begin miscompares++; $display("FAIL oor_rd_sdt: got %h, expected 0", c_dat); end
    vectors++; if (c_lat !== 1) begin miscompares++; $display("FAIL oor_latency: got %0d, expected 1", c_lat); end
    bus_classic(1'b1, 32'h400, 32'h00000BAD, 4'hF);
    vectors++; if (c_err !== 1'b1) begin miscompares++; $display("FAIL oor_wr_err: got %b, expected 1", c_err); end
    bus_classic(1'b0, 32'h0, 32'h0, 4'hF);
    vectors++; if (c_dat !== 32'h0) begin miscompares++; $display("FAIL oor_word0: got %h, expected 0", c_dat); end
    bus_burst(32'h3F8, 4, 2'b00, 99, 0);
    vectors++; if (be[0] !== 1'b0 || be[1] !== 1'b0) begin miscompares++; $display("FAIL oor_burst_inrange: got err %b%b, expected 00", be[0], be[1]); end
    vectors++; if (be[2] !== 1'b1 || be[3] !== 1'b1) begin miscompares++; $display("FAIL oor_burst_err: got err %b%b, expected 11", be[2], be[3]); end
    vectors++; if (bd[2] !== 32'h0) begin miscompares++; $display("FAIL oor_burst_sdt: got %h, expected 0", bd[2]); end
    idle();
  endtask

  task automatic test_stall();
    use3 = 1'b0;
    bus_burst(32'h00, 4, 2'b01, 2, 2);
    vectors++; if (b_quiet !== 2) begin miscompares++; $display("FAIL stall_low: got %0d, expected 2", b_quiet); end
    vectors++; if (b_bad !== 0) begin miscompares++; $display("FAIL stall_ack: got %0d, expected 0", b_bad); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (bd[i] !== 32'(i)) begin miscompares++; $display("FAIL stall_beat%0d: got %h, expected %h", i, bd[i], i); end
    end
    idle();
  endtask

  task automatic test_cyc_drop();
    use3 = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 3'b010, 2'b01);
    tick();
    @(negedge clk);
    vectors++; if (m_ack !== 1'b1 || m_sdt !== 32'h0) begin miscompares++; $display("FAIL drop_beat0: got ack %b data %h, expected ack 1 data 0", m_ack, m_sdt); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'hF, 3'b010, 2'b01);
    @(negedge clk);
    vectors++; if (m_ack !== 1'b0 || m_err !== 1'b0) begin miscompares++; $display("FAIL drop_quiet: got ack %b err %b, expected 0 0", m_ack, m_err); end
    tick();
    bus_classic(1'b0, 32'h08, 32'h0, 4'hF);
    vectors++; if (c_lat !== 1 || c_dat !== 32'h2) begin miscompares++; $display("FAIL drop_idle: got lat %0d data %h, expected lat 1 data 2", c_lat, c_dat); end
  endtask

  task automatic test_reset_mid_burst();
    use3 = 1'b0;
    wr(32'h1C, 32'h77777777);
    drive(1'b1, 1'b1, 1'b1, 32'h18, 32'h66666666, 4'hF, 3'b010, 2'b00);
    tick();
    @(negedge clk);
    vectors++; if (m_ack !== 1'b1) begin miscompares++; $display("FAIL rstb_beat0: got %b, expected 1", m_ack); end
    tick();
    adr = 32'h1C; dat = 32'hBADBAD00; rst = 1'b1;
    tick();
    @(negedge clk);
    vectors++; if (ack0 !== 1'b0 || err0 !== 1'b0 || sdt0 !== 32'h0) begin miscompares++; $display("FAIL rstb_outputs: got ack %b err %b sdt %h, expected all 0", ack0, err0, sdt0); end
    tick();
    rst = 1'b0;
    idle();
    bus_classic(1'b0, 32'h1C, 32'h0, 4'hF);
    vectors++; if (c_dat !== 32'h77777777) begin miscompares++; $display("FAIL rstb_nowrite: got %h, expected 77777777", c_dat); end
    bus_classic(1'b0, 32'h18, 32'h0, 4'hF);
    vectors++; if (c_dat !== 32'h66666666) begin miscompares++; $display("FAIL rstb_beat0_kept: got %h, expected 66666666", c_dat); end
  endtask

  initial begin
    use3 = 1'b0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 2'b00);
    test_reset();
    test_classic();
    test_byte_lanes();
    test_wrap_burst();
    test_back_to_back();
    test_wait_states();
    test_out_of_range();
    test_stall();
    test_cyc_drop();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
